// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the iterative RV32M divider:
//   - XLEN            : operand / result width
//   - DIV_OP_*        : div_op encodings (bit0 = unsigned, bit1 = remainder)
//   - state_t         : controller states S_IDLE / S_CALC / S_DONE
//   - op_is_signed()  : true for DIV / REM
//   - op_is_rem()     : true for REM / REMU
// ---------------------------------------------------------------------------
package div_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// ---------------------------------------------------------------------------
// div_iter_step
// One combinational restoring-division step.
//   rem_in   : partial remainder (always < divisor on entry)
//   dvd_msb  : next dividend bit shifted into the remainder
//   divisor  : unsigned divisor magnitude
//   rem_out  : partial remainder after the step
//   q_bit    : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Because rem_in < divisor, the shifted value is below 2*divisor, so an
    // XLEN+1 bit trial subtraction is enough: its MSB is the borrow/sign.
    always_comb begin
        shifted = {rem_in, dvd_msb};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[XLEN];
        rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Iterative radix-2 restoring divider for DIV / DIVU / REM / REMU.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   flush                : synchronous abort of any pending/in-flight op
//   div_valid/div_ready  : request handshake (div_op, src1, src2)
//   res_valid/res_ready  : result handshake (result)
// Latency: divide-by-zero and signed overflow finish one cycle after accept;
// all other operations finish XLEN+1 cycles after accept.
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN  = div_unit_pkg::XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result
);

    import div_unit_pkg::*;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q,   state_d;
    logic [1:0]        op_q,      op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   dvd_q,     dvd_d;     // dividend, becomes quotient
    logic [XLEN-1:0]   dvs_q,     dvs_d;     // divisor magnitude
    logic [XLEN-1:0]   rem_q,     rem_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [XLEN-1:0]   result_q,  result_d;

    logic              accept;
    logic              req_signed;
    logic [XLEN-1:0]   abs_src1;
    logic [XLEN-1:0]   abs_src2;
    logic [XLEN-1:0]   step_rem;
    logic              step_q;
    logic [XLEN-1:0]   quo_final;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;

    assign div_ready = (state_q == S_IDLE) && !flush;
    assign res_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign accept    = div_valid && div_ready;

    div_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_in  (rem_q),
        .dvd_msb (dvd_q[XLEN-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        req_signed = op_is_signed(div_op);
        abs_src1   = (req_signed && src1[XLEN-1]) ? -src1 : src1;
        abs_src2   = (req_signed && src2[XLEN-1]) ? -src2 : src2;

        // Final iteration result, sign-corrected for the last CALC cycle.
        quo_final = {dvd_q[XLEN-2:0], step_q};
        quo_fixed = neg_quo_q ? -quo_final : quo_final;
        rem_fixed = neg_rem_q ? -step_rem  : step_rem;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = div_op;
                    neg_quo_d = req_signed && (src1[XLEN-1] ^ src2[XLEN-1]);
                    neg_rem_d = req_signed && src1[XLEN-1];
                    dvd_d     = abs_src1;
                    dvs_d     = abs_src2;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(XLEN);
                    if (src2 == '0) begin
                        result_d = op_is_rem(div_op) ? src1 : '1;
                        state_d  = S_DONE;
                    end else if (req_signed && (src1 == MOST_NEG) && (src2 == '1)) begin
                        result_d = op_is_rem(div_op) ? '0 : MOST_NEG;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                dvd_d = quo_final;
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = op_is_rem(op_q) ? rem_fixed : quo_fixed;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything else, including the result handshake.
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: directed vector table, backpressure,
// flush and asynchronous-reset sequences, then random operations compared
// against an arithmetic reference of the RV32M division rules.
// ---------------------------------------------------------------------------
module tb_div_unit;

    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_op    (div_op),
        .src1      (src1),
        .src2      (src2),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, act);
        end
    endtask

    // Reference: RV32M division rules in plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op == DIV_OP_DIV || op == DIV_OP_REM) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op == DIV_OP_REM || op == DIV_OP_REMU) ? r : q;
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if ((op == DIV_OP_DIV || op == DIV_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op with res_ready high; returns at a negedge with the unit idle.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int  n;
        int  lat;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        n = 0;
        while (!div_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " ready_before"}, {31'd0, div_ready}, 32'd1);
        div_op    = op;
        src1      = a;
        src2      = b;
        div_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1 div_valid = 1'b0;
        lat = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (res_valid) seen = 1'b1;
            if (div_ready) busy_ok = 1'b0;
        end
        check({name, " valid"}, {31'd0, seen}, 32'd1);
        check({name, " result"}, result, exp);
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy"}, {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        check({name, " idle_after"}, {30'd0, res_valid, div_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  stable;
        bit  quiet;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int  sel;

        vecs[0]  = '{"divu_100_7",   DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{"remu_100_7",   DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{"div_m100_7",   DIV_OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
        vecs[3]  = '{"rem_m100_7",   DIV_OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
        vecs[4]  = '{"rem_100_m7",   DIV_OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          33};
        vecs[5]  = '{"divu_5_0",     DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[6]  = '{"rem_5_0",      DIV_OP_REM,  32'd5,          32'd0,          32'd5,          1};
        vecs[7]  = '{"div_ovf",      DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[8]  = '{"rem_ovf",      DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[9]  = '{"div_5_0",      DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[10] = '{"divu_max_2",   DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33};

        // Reset state
        #1;
        check("reset ready", {31'd0, div_ready}, 32'd1);
        check("reset valid", {31'd0, res_valid}, 32'd0);
        check("reset result", result, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Backpressure: hold result for 10 cycles with a stray request
        @(negedge clk);
        res_ready = 1'b0;
        div_op = DIV_OP_DIVU;
        src1 = 32'd1000;
        src2 = 32'd10;
        div_valid = 1'b1;
        @(posedge clk);
        #1 div_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 100);
        check("bp valid", {31'd0, res_valid}, 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!res_valid || result !== 32'd100 || div_ready) stable = 1'b0;
            if (i == 3) begin
                div_op = DIV_OP_DIVU;
                src1 = 32'd7;
                src2 = 32'd7;
                div_valid = 1'b1;
            end else begin
                div_valid = 1'b0;
            end
        end
        check("bp stable", {31'd0, stable}, 32'd1);
        check("bp result", result, 32'd100);
        res_ready = 1'b1;
        @(negedge clk);
        check("bp idle_after", {30'd0, res_valid, div_ready}, 32'd1);
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (res_valid || !div_ready) quiet = 1'b0;
        end
        check("bp no_accept", {31'd0, quiet}, 32'd1);

        // Flush at T+10, with a request presented in the flush cycle
        @(negedge clk);
        div_op = DIV_OP_DIVU;
        src1 = 32'h0000_FFFF;
        src2 = 32'd3;
        div_valid = 1'b1;
        @(posedge clk);
        #1 div_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        src1 = 32'd81;
        src2 = 32'd9;
        div_valid = 1'b1;
        #1;
        check("flush ready_low", {31'd0, div_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        div_valid = 1'b0;
        @(negedge clk);
        check("flush idle_next", {30'd0, res_valid, div_ready}, 32'd1);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (res_valid || !div_ready) quiet = 1'b0;
        end
        check("flush quiet", {31'd0, quiet}, 32'd1);
        do_op("divu_81_9", DIV_OP_DIVU, 32'd81, 32'd9, 32'd9, 33);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        div_op = DIV_OP_DIVU;
        src1 = 32'h0000_FFFF;
        src2 = 32'd3;
        div_valid = 1'b1;
        @(posedge clk);
        #1 div_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("areset ready", {31'd0, div_ready}, 32'd1);
        check("areset valid", {31'd0, res_valid}, 32'd0);
        check("areset result", result, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        do_op("divu_max_1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        // Random operations against the reference model
        for (int i = 0; i < 200; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                rb = 32'd0;
            end else if (sel == 1) begin
                rb = 32'hFFFF_FFFF;
                if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000;
            end else if (sel == 2) begin
                rb = $urandom_range(1, 15);
            end else begin
                rb = $urandom >> $urandom_range(0, 31);
            end
            do_op($sformatf("rand%0d op%0d %h/%h", i, rop, ra, rb), rop, ra, rb,
                  model(rop, ra, rb), model_lat(rop, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
